// File: rtl/axil_uart_pkg.sv
// Shared types and constants for the AXI-Lite UART scheduler.
package axil_uart_pkg;

  localparam int unsigned BYTE_W = 8;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE,
    POLL_AR,
    POLL_R,
    DECIDE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R
  } state_t;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // UART status register bit positions
  localparam int unsigned STAT_RX_AVAIL_BIT = 0;
  localparam int unsigned STAT_TX_FULL_BIT  = 1;

  // Default UART register map
  localparam logic [15:0] DEF_RX_ADDR   = 16'h0000;
  localparam logic [15:0] DEF_TX_ADDR   = 16'h0004;
  localparam logic [15:0] DEF_STAT_ADDR = 16'h0008;

endpackage

// File: rtl/axil_uart_scheduler_hold.sv
// One-entry valid/ready byte holding register.
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   in_data/in_valid/in_ready        load side; in_ready is high while empty
//   out_data/out_valid/out_ready     drain side; out_valid is high while full
module axil_byte_hold
  import axil_uart_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              full_q;
  logic [BYTE_W-1:0] data_q;

  // Load only while empty, drain only while full, so the two never collide
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid && !full_q) begin
      full_q <= 1'b1;
      data_q <= in_data;
    end else if (full_q && out_ready) begin
      full_q <= 1'b0;
    end
  end

  assign in_ready  = !full_q;
  assign out_valid = full_q;
  assign out_data  = data_q;

endmodule

// File: rtl/axil_uart_scheduler.sv
// AXI-Lite master that polls a UART status register and shares the port
// round-robin between TX data writes and RX data reads.
// Ports:
//   clock, reset           clock and synchronous active-high reset
//   enable                 0 = finish the current transaction, then park in IDLE
//   tx_data/valid/ready    TX byte stream in (tx_ready = TX holding register empty)
//   rx_data/valid/ready    RX byte stream out (rx_valid = RX holding register full)
//   m_axi_*                AXI-Lite master (AW, W, B, AR, R channels)
//   err_flag               sticky error-response flag
//   err_count              saturating count of error responses
module axil_uart_scheduler
  import axil_uart_pkg::*;
#(
  parameter int unsigned                P_ADDR_WIDTH = 16,
  parameter int unsigned                P_DATA_WIDTH = 32,
  parameter logic [P_ADDR_WIDTH-1:0]    P_RX_ADDR    = P_ADDR_WIDTH'(DEF_RX_ADDR),
  parameter logic [P_ADDR_WIDTH-1:0]    P_TX_ADDR    = P_ADDR_WIDTH'(DEF_TX_ADDR),
  parameter logic [P_ADDR_WIDTH-1:0]    P_STAT_ADDR  = P_ADDR_WIDTH'(DEF_STAT_ADDR),
  parameter int unsigned                P_POLL_GAP   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [BYTE_W-1:0]       rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [P_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [P_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [P_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [P_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    err_flag,
  output logic [7:0]              err_count
);

  localparam int unsigned      GAP_W      = $clog2(P_POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(P_POLL_GAP - 1);

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              rr_last_rx_q, rr_last_rx_d;
  logic              stat_rx_avail_q, stat_tx_full_q;

  logic [P_ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic [P_DATA_WIDTH-1:0] wdata_d;
  logic                    awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

  logic              tx_pending_c, rx_space_c;
  logic [BYTE_W-1:0] tx_byte_c;
  logic              ar_hs_c, r_hs_c, b_hs_c, aw_done_c, w_done_c;
  logic              rresp_ok_c, tx_ok_c, rx_ok_c, enter_wr_c, err_c;
  logic              unused_rdata_hi;

  assign ar_hs_c    = m_axi_arvalid && m_axi_arready;
  assign r_hs_c     = m_axi_rvalid && m_axi_rready;
  assign b_hs_c     = m_axi_bvalid && m_axi_bready;
  assign aw_done_c  = !m_axi_awvalid || m_axi_awready;
  assign w_done_c   = !m_axi_wvalid || m_axi_wready;
  assign rresp_ok_c = (m_axi_rresp == RESP_OKAY);
  assign tx_ok_c    = tx_pending_c && !stat_tx_full_q;
  assign rx_ok_c    = stat_rx_avail_q && rx_space_c;
  assign err_c      = (r_hs_c && !rresp_ok_c) || (b_hs_c && (m_axi_bresp != RESP_OKAY));
  assign unused_rdata_hi = ^m_axi_rdata[P_DATA_WIDTH-1:BYTE_W];

  // TX holding register: drained by the B handshake whatever the response
  axil_byte_hold u_tx_hold (
    .clock     (clock),
    .reset     (reset),
    .in_data   (tx_data),
    .in_valid  (tx_valid),
    .in_ready  (tx_ready),
    .out_data  (tx_byte_c),
    .out_valid (tx_pending_c),
    .out_ready ((state_q == WR_B) && b_hs_c)
  );

  // RX holding register: loaded by an OKAY read of the RX data register
  axil_byte_hold u_rx_hold (
    .clock     (clock),
    .reset     (reset),
    .in_data   (m_axi_rdata[BYTE_W-1:0]),
    .in_valid  ((state_q == RD_R) && r_hs_c && rresp_ok_c),
    .in_ready  (rx_space_c),
    .out_data  (rx_data),
    .out_valid (rx_valid),
    .out_ready (rx_ready)
  );

  // State, poll gap and round-robin registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      rr_last_rx_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      rr_last_rx_q <= rr_last_rx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    rr_last_rx_d = rr_last_rx_q;
    unique case (state_q)
      IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (enable && (tx_pending_c || rx_space_c)) begin
          state_d = POLL_AR;
        end
      end
      POLL_AR: if (ar_hs_c) state_d = POLL_R;
      POLL_R:  if (r_hs_c)  state_d = DECIDE;
      DECIDE: begin
        if (tx_ok_c && rx_ok_c) begin
          // Tie: serve the side not served last time
          state_d      = rr_last_rx_q ? WR_AW_W : RD_AR;
          rr_last_rx_d = !rr_last_rx_q;
        end else if (tx_ok_c) begin
          state_d = WR_AW_W;
        end else if (rx_ok_c) begin
          state_d = RD_AR;
        end else begin
          state_d = IDLE;
          gap_d   = GAP_RELOAD;
        end
      end
      WR_AW_W: if (aw_done_c && w_done_c) state_d = WR_B;
      WR_B:    if (b_hs_c) state_d = enable ? POLL_AR : IDLE;
      RD_AR:   if (ar_hs_c) state_d = RD_R;
      RD_R:    if (r_hs_c)  state_d = enable ? POLL_AR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_wr_c = (state_q == DECIDE) && (state_d == WR_AW_W);

  // AXI output next values, derived from the next state so outputs are registered
  always_comb begin
    awaddr_d  = m_axi_awaddr;
    wdata_d   = m_axi_wdata;
    araddr_d  = m_axi_araddr;
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    if (enter_wr_c) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = P_TX_ADDR;
      wdata_d   = P_DATA_WIDTH'(tx_byte_c);
    end else if (state_q == WR_AW_W) begin
      // AW and W retire independently
      awvalid_d = m_axi_awvalid && !m_axi_awready;
      wvalid_d  = m_axi_wvalid && !m_axi_wready;
    end
    if ((state_d == POLL_AR) && (state_q != POLL_AR)) araddr_d = P_STAT_ADDR;
    if ((state_d == RD_AR) && (state_q != RD_AR))     araddr_d = P_RX_ADDR;
    arvalid_d = (state_d == POLL_AR) || (state_d == RD_AR);
    rready_d  = (state_d == POLL_R) || (state_d == RD_R);
    bready_d  = (state_d == WR_B);
  end

  // AXI output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      m_axi_awaddr  <= awaddr_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_araddr  <= araddr_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
    end
  end

  // Status capture; an errored poll reads as no work either way
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_rx_avail_q <= 1'b0;
      stat_tx_full_q  <= 1'b0;
    end else if ((state_q == POLL_R) && r_hs_c) begin
      stat_rx_avail_q <= rresp_ok_c && m_axi_rdata[STAT_RX_AVAIL_BIT];
      stat_tx_full_q  <= rresp_ok_c && m_axi_rdata[STAT_TX_FULL_BIT];
    end
  end

  // Sticky error flag and saturating error counter
  always_ff @(posedge clock) begin
    if (reset) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (err_c) begin
      err_flag <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_axil_uart_scheduler.sv
// Directed testbench for axil_uart_scheduler with a small behavioural UART slave.
module tb_axil_uart_scheduler;

  localparam logic [15:0] RX_ADDR   = 16'h0000;
  localparam logic [15:0] TX_ADDR   = 16'h0004;
  localparam logic [15:0] STAT_ADDR = 16'h0008;
  localparam int          POLL_GAP  = 16;

  logic        clock = 1'b0;
  logic        reset, enable;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic        err_flag;
  logic [7:0]  err_count;

  logic [31:0] stat_val;
  logic [7:0]  rx_byte_val;
  logic [15:0] last_ar = 16'h0;
  logic        rec_en;
  logic [7:0]  order_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  axil_uart_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .err_flag      (err_flag),
    .err_count     (err_count)
  );

  // Slave read data follows the address of the last AR handshake
  always @(posedge clock) begin
    if (m_axi_arvalid && m_axi_arready) last_ar <= m_axi_araddr;
  end
  assign m_axi_rdata = (last_ar == STAT_ADDR) ? stat_val : {24'h0, rx_byte_val};

  // Transaction order recorder: 'W' for TX writes, 'R' for RX data reads
  always @(posedge clock) begin
    if (rec_en) begin
      if (m_axi_awvalid && m_axi_awready) order_q.push_back(8'h57);
      if (m_axi_arvalid && m_axi_arready && (m_axi_araddr == RX_ADDR)) order_q.push_back(8'h52);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Flush any pending work with no status bits set, then park in IDLE with the gap expired
  task automatic park();
    stat_val = 32'h0;
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    enable   = 1'b1;
    repeat (40) tick();
    enable = 1'b0;
    repeat (40) tick();
  endtask

  int n;
  int aw_seen;

  initial begin
    reset = 1'b1; enable = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_rvalid = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; m_axi_rresp = 2'b00;
    stat_val = 32'h0; rx_byte_val = 8'h5A; rec_en = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset values
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_valids", {28'h0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready}, 32'h0);
    chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 32'h0);
    chk("rst_err", {23'h0, err_flag, err_count}, 32'h0);

    // TX blocked by tx_full: no AW, re-poll after the gap, then write goes out
    stat_val = 32'h2; tx_data = 8'h41; tx_valid = 1'b1; enable = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("blk_tx_ready_low", 32'(tx_ready), 32'd0);
    chk("blk_poll_arvalid", 32'(m_axi_arvalid), 32'd1);
    chk("blk_poll_araddr", 32'(m_axi_araddr), 32'(STAT_ADDR));
    tick();
    chk("blk_poll_rready", 32'(m_axi_rready), 32'd1);
    tick();
    tick();
    chk("blk_no_aw", 32'(m_axi_awvalid), 32'd0);
    stat_val = 32'h0;
    n = 0; aw_seen = 0;
    while (!m_axi_arvalid && n < 50) begin
      tick(); n++;
      if (m_axi_awvalid) aw_seen++;
    end
    chk("blk_gap_cycles", 32'(n), 32'(POLL_GAP));
    chk("blk_no_aw_in_gap", 32'(aw_seen), 32'd0);
    n = 0;
    while (!m_axi_awvalid && n < 20) begin tick(); n++; end
    chk("blk_awaddr", 32'(m_axi_awaddr), 32'(TX_ADDR));
    chk("blk_wdata", m_axi_wdata, 32'h0000_0041);
    n = 0;
    while (!tx_ready && n < 20) begin tick(); n++; end
    chk("blk_tx_ready_back", 32'(tx_ready), 32'd1);
    park();

    // Latency from byte acceptance to awvalid with a zero-wait slave
    tx_data = 8'h42; tx_valid = 1'b1; enable = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      tx_valid = 1'b0;
    end while (!m_axi_awvalid && n < 20);
    chk("lat_cycles", 32'(n), 32'd4);
    chk("lat_wdata", m_axi_wdata, 32'h0000_0042);
    park();

    // RX pop with consumer ready: rx_valid for exactly one cycle
    stat_val = 32'h1; rx_ready = 1'b1; enable = 1'b1;
    n = 0;
    while (!rx_valid && n < 30) begin tick(); n++; end
    chk("rx_valid_set", 32'(rx_valid), 32'd1);
    chk("rx_data", 32'(rx_data), 32'h5A);
    tick();
    chk("rx_valid_one_cycle", 32'(rx_valid), 32'd0);

    // RX holding register full: byte held and polling stops
    rx_ready = 1'b0;
    n = 0;
    while (!rx_valid && n < 60) begin tick(); n++; end
    repeat (20) tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_axi_arvalid) n++;
      tick();
    end
    chk("rx_full_no_poll", 32'(n), 32'd0);
    chk("rx_full_held", {23'h0, rx_valid, rx_data}, 32'h15A);
    park();

    // Round robin with both sides ready: W, R, W, R
    stat_val = 32'h1; tx_data = 8'h33; tx_valid = 1'b1; rx_ready = 1'b1;
    rec_en = 1'b1; enable = 1'b1;
    n = 0;
    while (order_q.size() < 4 && n < 300) begin tick(); n++; end
    rec_en = 1'b0; tx_valid = 1'b0;
    chk("rr_count", 32'(order_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < order_q.size()) chk($sformatf("rr_order%0d", i), 32'(order_q[i]), (i % 2 == 0) ? 32'h57 : 32'h52);
    end
    park();

    // AW delayed three cycles, W accepted immediately
    m_axi_awready = 1'b0; tx_data = 8'h55; tx_valid = 1'b1; enable = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (!m_axi_awvalid && n < 10) begin tick(); n++; end
    chk("awd_c1", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h6);
    tick();
    chk("awd_c2", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h4);
    tick();
    chk("awd_c3", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h4);
    tick();
    m_axi_awready = 1'b1;
    chk("awd_c4", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h4);
    chk("awd_c4_addr_data", {m_axi_awaddr, m_axi_wdata[15:0]}, {TX_ADDR, 16'h0055});
    tick();
    chk("awd_c5", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h1);
    park();

    // Error write response: flag, count, byte dropped
    m_axi_bresp = 2'b10; tx_data = 8'h77; tx_valid = 1'b1; enable = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (!m_axi_bready && n < 20) begin tick(); n++; end
    tick();
    m_axi_bresp = 2'b00;
    chk("berr_flag", 32'(err_flag), 32'd1);
    chk("berr_count", 32'(err_count), 32'd1);
    chk("berr_tx_ready", 32'(tx_ready), 32'd1);
    park();

    // Errored status polls until the counter saturates
    m_axi_rresp = 2'b10; enable = 1'b1;
    n = 0;
    while (err_count != 8'hFF && n < 20000) begin tick(); n++; end
    chk("sat_reached", 32'(err_count), 32'hFF);
    repeat (100) tick();
    chk("sat_hold", 32'(err_count), 32'hFF);
    chk("sat_flag", 32'(err_flag), 32'd1);
    m_axi_rresp = 2'b00;
    park();

    // Reset while in WR_AW_W
    m_axi_awready = 1'b0; tx_data = 8'h41; tx_valid = 1'b1; enable = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (!m_axi_awvalid && n < 10) begin tick(); n++; end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_axi_awready = 1'b1;
    chk("rstw_valids", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h0);
    chk("rstw_tx_ready", 32'(tx_ready), 32'd1);
    chk("rstw_err", {23'h0, err_flag, err_count}, 32'h0);
    tick();
    chk("rstw_idle_to_poll", {15'h0, m_axi_arvalid, m_axi_araddr}, {15'h0, 1'b1, STAT_ADDR});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
